// File: rtl/player_cmd_pkg.sv
// -----------------------------------------------------------------------------
// player_cmd_pkg
// Shared definitions for the player instruction bus: op codes, direction
// codes, instruction field layout, one-hot grant codes, the arbiter FSM state
// type and small helpers for packing instructions and saturating addition.
// The Machine page controller uses the same constants.
// -----------------------------------------------------------------------------
package player_cmd_pkg;

    // Op codes carried in playerInstruction[15:12]
    localparam logic [3:0] OP_SHP = 4'h6;
    localparam logic [3:0] OP_HPY = 4'h1;
    localparam logic [3:0] OP_DPY = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h5;

    // Movement directions carried in the low bits of the MOV argument
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Instruction field layout: {op[15:12], arg[11:4], pad[3:0]}
    localparam int INSTR_OP_MSB  = 15;
    localparam int INSTR_OP_LSB  = 12;
    localparam int INSTR_ARG_MSB = 11;
    localparam int INSTR_ARG_LSB = 4;
    localparam logic [3:0] INSTR_PAD = 4'b0000;

    // One-hot grant codes: [3]=SHP, [2]=HPY, [1]=DPY, [0]=MOV
    localparam logic [3:0] GNT_NONE = 4'b0000;
    localparam logic [3:0] GNT_SHP  = 4'b1000;
    localparam logic [3:0] GNT_HPY  = 4'b0100;
    localparam logic [3:0] GNT_DPY  = 4'b0010;
    localparam logic [3:0] GNT_MOV  = 4'b0001;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Build a 16-bit player instruction from an op code and its argument
    function automatic logic [15:0] pack_instr(input logic [3:0] op,
                                               input logic [7:0] arg);
        return {op, arg, INSTR_PAD};
    endfunction

    // min(a + b, ceiling) computed with a 9-bit intermediate so the carry
    // out of the 8-bit add is never lost
    function automatic logic [7:0] sat_add8(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] ceiling);
        logic [8:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, ceiling}) begin
            return ceiling;
        end else begin
            return sum_s[7:0];
        end
    endfunction

endpackage

// File: rtl/player_cmd_arbiter_slot.sv
// -----------------------------------------------------------------------------
// cmd_pending_slot
// One latched one-shot command: a pending flag plus an 8-bit payload.
//   SAT_ADD = 0 : payload is overwritten by each request (last value wins)
//   SAT_ADD = 1 : payload accumulates requests, saturating at SAT_MAX
// A request arriving on the same edge as the clear re-arms the slot with the
// new request's value, so nothing is lost across a handshake. flush wins
// over everything, including a same-edge request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of flag and payload
//   set, set_val    request pulse and the value captured with it
//   clr             granted instruction for this slot has been accepted
//   pend, payload   registered flag and payload
//   pend_nxt        value pend will take on the next edge
// -----------------------------------------------------------------------------
module cmd_pending_slot
    import player_cmd_pkg::*;
#(
    parameter bit         SAT_ADD = 1'b0,
    parameter logic [7:0] SAT_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       set,
    input  logic [7:0] set_val,
    input  logic       clr,
    output logic       pend,
    output logic [7:0] payload,
    output logic       pend_nxt
);

    logic       pend_r;
    logic [7:0] payload_r;
    logic       pend_nxt_s;
    logic [7:0] payload_nxt_s;

    // Next flag/payload: flush > clear (with re-arm) > capture > hold
    always_comb begin
        pend_nxt_s    = pend_r;
        payload_nxt_s = payload_r;
        if (flush) begin
            pend_nxt_s    = 1'b0;
            payload_nxt_s = 8'd0;
        end else if (clr) begin
            if (set) begin
                pend_nxt_s = 1'b1;
                if (SAT_ADD) begin
                    payload_nxt_s = sat_add8(8'd0, set_val, SAT_MAX);
                end else begin
                    payload_nxt_s = set_val;
                end
            end else begin
                pend_nxt_s = 1'b0;
                if (SAT_ADD) begin
                    payload_nxt_s = 8'd0;
                end else begin
                    payload_nxt_s = payload_r;
                end
            end
        end else if (set) begin
            pend_nxt_s = 1'b1;
            if (SAT_ADD) begin
                payload_nxt_s = sat_add8(payload_r, set_val, SAT_MAX);
            end else begin
                payload_nxt_s = set_val;
            end
        end else begin
            pend_nxt_s    = pend_r;
            payload_nxt_s = payload_r;
        end
    end

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= 1'b0;
            payload_r <= 8'd0;
        end else begin
            pend_r    <= pend_nxt_s;
            payload_r <= payload_nxt_s;
        end
    end

    assign pend     = pend_r;
    assign payload  = payload_r;
    assign pend_nxt = pend_nxt_s;

endmodule

// File: rtl/player_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// player_cmd_arbiter
// Shares the 16-bit player instruction bus between set-HP, heal, damage and
// movement. One-shot commands are latched in pending slots; movement is a
// level request gated by enable and rate-limited by a cooldown counter.
// Priority SHP > HPY > DPY > MOV. Each instruction is handed off with a
// valid/ready handshake and is followed by one idle bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              dodge phase active; gates MOV grants only
//   flush               synchronous clear of pending work and in-flight instr
//   shpReq/shpVal       set-HP request and value
//   healReq             heal request (argument is HEAL_AMT)
//   dmgReq/dmgVal       damage request and amount (accumulated, saturating)
//   moveReq/moveDir     movement key level and direction
//   playerInstruction   {op[3:0], arg[7:0], 4'b0000}
//   instrValid          playerInstruction is valid
//   instrReady          player accepts the instruction
//   grant               one-hot source of the current instruction
//   busy                any request pending or instruction in flight
// -----------------------------------------------------------------------------
module player_cmd_arbiter
    import player_cmd_pkg::*;
#(
    parameter logic [7:0]  HEAL_AMT = 8'd10,
    parameter logic [15:0] MOVE_DIV = 16'd4,
    parameter logic [7:0]  DMG_MAX  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        shpReq,
    input  logic [7:0]  shpVal,
    input  logic        healReq,
    input  logic        dmgReq,
    input  logic [7:0]  dmgVal,
    input  logic        moveReq,
    input  logic [1:0]  moveDir,
    output logic [15:0] playerInstruction,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [3:0]  grant,
    output logic        busy
);

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;
    logic [15:0] instr_r;
    logic [15:0] instr_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
    logic [3:0]  grant_r;
    logic [3:0]  grant_nxt_s;
    logic        busy_r;
    logic        busy_nxt_s;
    logic [15:0] move_cnt_r;
    logic [15:0] move_cnt_nxt_s;
    logic        handshake_s;

    logic        shp_pend_s,  heal_pend_s,  dmg_pend_s;
    logic        shp_pnxt_s,  heal_pnxt_s,  dmg_pnxt_s;
    logic [7:0]  shp_arg_s,   heal_arg_s,   dmg_arg_s;
    logic        shp_clr_s,   heal_clr_s,   dmg_clr_s;
    logic        any_pend_s;
    logic        mov_elig_s;

    // Only the slot whose instruction was just accepted is cleared
    assign shp_clr_s  = handshake_s && (grant_r == GNT_SHP);
    assign heal_clr_s = handshake_s && (grant_r == GNT_HPY);
    assign dmg_clr_s  = handshake_s && (grant_r == GNT_DPY);

    // Set-HP: last value wins
    cmd_pending_slot #(.SAT_ADD(1'b0), .SAT_MAX(8'd255)) u_shp_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set      (shpReq),
        .set_val  (shpVal),
        .clr      (shp_clr_s),
        .pend     (shp_pend_s),
        .payload  (shp_arg_s),
        .pend_nxt (shp_pnxt_s)
    );

    // Heal: every request loads the fixed heal amount, so repeats merge
    cmd_pending_slot #(.SAT_ADD(1'b0), .SAT_MAX(8'd255)) u_heal_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set      (healReq),
        .set_val  (HEAL_AMT),
        .clr      (heal_clr_s),
        .pend     (heal_pend_s),
        .payload  (heal_arg_s),
        .pend_nxt (heal_pnxt_s)
    );

    // Damage: saturating accumulator
    cmd_pending_slot #(.SAT_ADD(1'b1), .SAT_MAX(DMG_MAX)) u_dmg_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set      (dmgReq),
        .set_val  (dmgVal),
        .clr      (dmg_clr_s),
        .pend     (dmg_pend_s),
        .payload  (dmg_arg_s),
        .pend_nxt (dmg_pnxt_s)
    );

    assign any_pend_s = shp_pend_s | heal_pend_s | dmg_pend_s;
    assign mov_elig_s = moveReq & enable & (move_cnt_r == 16'd0) & ~any_pend_s;

    // Arbitration FSM: pick in IDLE, hold in ISSUE until the handshake
    always_comb begin
        state_nxt_s = state_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        grant_nxt_s = grant_r;
        handshake_s = 1'b0;
        if (flush) begin
            state_nxt_s = ST_IDLE;
            instr_nxt_s = 16'h0000;
            valid_nxt_s = 1'b0;
            grant_nxt_s = GNT_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (shp_pend_s) begin
                        instr_nxt_s = pack_instr(OP_SHP, shp_arg_s);
                        grant_nxt_s = GNT_SHP;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else if (heal_pend_s) begin
                        instr_nxt_s = pack_instr(OP_HPY, heal_arg_s);
                        grant_nxt_s = GNT_HPY;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else if (dmg_pend_s) begin
                        instr_nxt_s = pack_instr(OP_DPY, dmg_arg_s);
                        grant_nxt_s = GNT_DPY;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else if (mov_elig_s) begin
                        // direction is frozen here for the life of the MOV
                        instr_nxt_s = pack_instr(OP_MOV, {6'b000000, moveDir});
                        grant_nxt_s = GNT_MOV;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        instr_nxt_s = 16'h0000;
                        grant_nxt_s = GNT_NONE;
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (valid_r && instrReady) begin
                        // returning to IDLE forces the one-cycle bubble
                        handshake_s = 1'b1;
                        instr_nxt_s = 16'h0000;
                        grant_nxt_s = GNT_NONE;
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        instr_nxt_s = instr_r;
                        grant_nxt_s = grant_r;
                        valid_nxt_s = valid_r;
                        state_nxt_s = ST_ISSUE;
                    end
                end
                default: begin
                    instr_nxt_s = 16'h0000;
                    grant_nxt_s = GNT_NONE;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Movement cooldown: reload on MOV acceptance, otherwise count down to 0
    always_comb begin
        move_cnt_nxt_s = move_cnt_r;
        if (flush) begin
            move_cnt_nxt_s = 16'd0;
        end else if (handshake_s && (grant_r == GNT_MOV)) begin
            move_cnt_nxt_s = MOVE_DIV - 16'd1;
        end else if (move_cnt_r != 16'd0) begin
            move_cnt_nxt_s = move_cnt_r - 16'd1;
        end else begin
            move_cnt_nxt_s = move_cnt_r;
        end
    end

    // busy is registered from next-state values so it tracks the flags exactly
    assign busy_nxt_s = shp_pnxt_s | heal_pnxt_s | dmg_pnxt_s | valid_nxt_s;

    // FSM, output and cooldown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            instr_r    <= 16'h0000;
            valid_r    <= 1'b0;
            grant_r    <= GNT_NONE;
            busy_r     <= 1'b0;
            move_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            instr_r    <= instr_nxt_s;
            valid_r    <= valid_nxt_s;
            grant_r    <= grant_nxt_s;
            busy_r     <= busy_nxt_s;
            move_cnt_r <= move_cnt_nxt_s;
        end
    end

    assign playerInstruction = instr_r;
    assign instrValid        = valid_r;
    assign grant             = grant_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_player_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_player_cmd_arbiter
// Scenario tasks drive the arbiter; every accepted instruction
// ({playerInstruction, grant} on a valid&&ready cycle) is logged with its
// cycle number and compared against expected entries queued by the tasks.
// -----------------------------------------------------------------------------
module tb_player_cmd_arbiter;
    import player_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        shpReq = 1'b0;
    logic [7:0]  shpVal = 8'd0;
    logic        healReq = 1'b0;
    logic        dmgReq = 1'b0;
    logic [7:0]  dmgVal = 8'd0;
    logic        moveReq = 1'b0;
    logic [1:0]  moveDir = 2'd0;
    logic        instrReady = 1'b0;
    logic [15:0] playerInstruction;
    logic        instrValid;
    logic [3:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];
    int          got_cyc_q[$];

    player_cmd_arbiter #(
        .HEAL_AMT(8'd10),
        .MOVE_DIV(16'd4),
        .DMG_MAX (8'd255)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .flush            (flush),
        .shpReq           (shpReq),
        .shpVal           (shpVal),
        .healReq          (healReq),
        .dmgReq           (dmgReq),
        .dmgVal           (dmgVal),
        .moveReq          (moveReq),
        .moveDir          (moveDir),
        .playerInstruction(playerInstruction),
        .instrValid       (instrValid),
        .instrReady       (instrReady),
        .grant            (grant),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every handshake: inputs settle at the falling edge, sampled 1 later
    always @(negedge clk) begin
        #1;
        if (instrValid === 1'b1 && instrReady === 1'b1) begin
            got_q.push_back({playerInstruction, grant});
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instrValid); end
        n_checks++;
        if (playerInstruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got=%h exp=0000", playerInstruction); end
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    // Heal and damage in one cycle: HPY first, one bubble, then DPY
    task automatic test_priority();
        logic [19:0] e, g;
        int c0, c1;
        instrReady = 1'b1;
        healReq = 1'b1; dmgReq = 1'b1; dmgVal = 8'd7;
        exp_q.push_back({16'h10A0, 4'b0100});
        exp_q.push_back({16'h2070, 4'b0010});
        tick();
        healReq = 1'b0; dmgReq = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL prio_count got=%0d exp=2", got_q.size());
        end else begin
            c0 = got_cyc_q[0]; c1 = got_cyc_q[1];
            n_checks++;
            if (c1 - c0 != 2) begin n_fail++; $display("FAIL prio_bubble gap=%0d exp=2", c1 - c0); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL prio_missing exp=%h", e);
            end else begin
                g = got_q.pop_front(); c0 = got_cyc_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL prio_instr got=%h exp=%h", g, e); end
            end
        end
        instrReady = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Damage accumulates while a heal is stalled; DPY carries saturated FF
    task automatic test_saturation();
        logic [19:0] e, g;
        int c0;
        bit stable;
        instrReady = 1'b0;
        healReq = 1'b1;
        exp_q.push_back({16'h10A0, 4'b0100});
        tick();
        healReq = 1'b0;
        tick();
        dmgReq = 1'b1; dmgVal = 8'd100;
        tick(); tick(); tick();
        dmgReq = 1'b0;
        n_checks++;
        if (instrValid !== 1'b1 || playerInstruction !== 16'h10A0) begin
            n_fail++; $display("FAIL sat_heal_hold valid=%b instr=%h exp=1/10A0", instrValid, playerInstruction);
        end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        exp_q.push_back({16'h2FF0, 4'b0010});
        tick();
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (instrValid !== 1'b1 || playerInstruction !== 16'h2FF0 || grant !== 4'b0010) stable = 1'b0;
            tick();
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL sat_hold instr=%h grant=%b exp=2FF0/0010", playerInstruction, grant); end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || instrValid !== 1'b0) begin
            n_fail++; $display("FAIL sat_busy_after busy=%b valid=%b exp=0/0", busy, instrValid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL sat_missing exp=%h", e);
            end else begin
                g = got_q.pop_front(); c0 = got_cyc_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL sat_instr got=%h exp=%h", g, e); end
            end
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Damage arriving on the DPY handshake edge re-arms a second DPY
    task automatic test_back_to_back();
        logic [19:0] e, g;
        int c0, c1;
        instrReady = 1'b0;
        dmgReq = 1'b1; dmgVal = 8'd9;
        exp_q.push_back({16'h2090, 4'b0010});
        tick();
        dmgReq = 1'b0;
        tick();
        instrReady = 1'b1; dmgReq = 1'b1; dmgVal = 8'd5;
        exp_q.push_back({16'h2050, 4'b0010});
        tick();
        dmgReq = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_count got=%0d exp=2", got_q.size());
        end else begin
            c0 = got_cyc_q[0]; c1 = got_cyc_q[1];
            n_checks++;
            if (c1 - c0 != 2) begin n_fail++; $display("FAIL b2b_bubble gap=%0d exp=2", c1 - c0); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_missing exp=%h", e);
            end else begin
                g = got_q.pop_front(); c0 = got_cyc_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b2b_instr got=%h exp=%h", g, e); end
            end
        end
        instrReady = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // MOV rate limit: after an accepted MOV the counter holds off re-issue
    // for MOVE_DIV-1 cycles, the next MOV appears 4 edges after acceptance
    // and is accepted one edge later, so accepted MOVs are 5 edges apart
    task automatic test_move();
        logic [19:0] e, g;
        int cs[3];
        int c0;
        bit quiet;
        instrReady = 1'b1; enable = 1'b1; moveReq = 1'b1; moveDir = DIR_RIGHT;
        for (int k = 0; k < 3; k++) exp_q.push_back({16'h5030, 4'b0001});
        for (int i = 0; i < 60 && got_q.size() < 3; i++) tick();
        enable = 1'b0;
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++; $display("FAIL mov_count got=%0d exp=3", got_q.size());
        end else begin
            for (int k = 0; k < 3; k++) cs[k] = got_cyc_q[k];
            n_checks++;
            if (cs[1] - cs[0] != 5 || cs[2] - cs[1] != 5) begin
                n_fail++; $display("FAIL mov_period gaps=%0d,%0d exp=5,5", cs[1] - cs[0], cs[2] - cs[1]);
            end
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (instrValid !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_checks++;
        if (!quiet || got_q.size() != 3) begin
            n_fail++; $display("FAIL mov_disabled valid_seen=%b handshakes=%0d exp=0/3", !quiet, got_q.size());
        end
        // direction frozen at grant; disabling does not cancel an in-flight MOV
        instrReady = 1'b0; enable = 1'b1;
        tick();
        exp_q.push_back({16'h5030, 4'b0001});
        enable = 1'b0; moveDir = DIR_UP;
        tick(); tick();
        n_checks++;
        if (instrValid !== 1'b1 || playerInstruction !== 16'h5030 || grant !== 4'b0001) begin
            n_fail++; $display("FAIL mov_frozen valid=%b instr=%h grant=%b exp=1/5030/0001", instrValid, playerInstruction, grant);
        end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0; moveReq = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL mov_missing exp=%h", e);
            end else begin
                g = got_q.pop_front(); c0 = got_cyc_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL mov_instr got=%h exp=%h", g, e); end
            end
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    // ------------------------------------------------------------------
    // flush drops the in-flight SHP, the pending heal and a same-cycle damage
    task automatic test_flush();
        bit quiet;
        instrReady = 1'b0;
        shpReq = 1'b1; shpVal = 8'h44;
        tick();
        shpReq = 1'b0; healReq = 1'b1;
        tick();
        healReq = 1'b0;
        n_checks++;
        if (instrValid !== 1'b1 || playerInstruction !== 16'h6440 || grant !== 4'b1000) begin
            n_fail++; $display("FAIL flush_pre valid=%b instr=%h grant=%b exp=1/6440/1000", instrValid, playerInstruction, grant);
        end
        flush = 1'b1; dmgReq = 1'b1; dmgVal = 8'd3;
        tick();
        flush = 1'b0; dmgReq = 1'b0;
        n_checks++;
        if (instrValid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear valid=%b grant=%b busy=%b exp=0/0000/0", instrValid, grant, busy);
        end
        instrReady = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (instrValid !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_checks++;
        if (!quiet || got_q.size() != 0) begin
            n_fail++; $display("FAIL flush_no_issue valid_seen=%b handshakes=%0d exp=0/0", !quiet, got_q.size());
        end
        instrReady = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Asynchronous reset mid-ISSUE clears outputs between clock edges
    task automatic test_async_reset();
        bit quiet;
        instrReady = 1'b0;
        shpReq = 1'b1; shpVal = 8'h33;
        tick();
        shpReq = 1'b0;
        tick();
        n_checks++;
        if (instrValid !== 1'b1 || playerInstruction !== 16'h6330) begin
            n_fail++; $display("FAIL arst_pre valid=%b instr=%h exp=1/6330", instrValid, playerInstruction);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instrValid !== 1'b0 || playerInstruction !== 16'h0000 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL arst_outputs valid=%b instr=%h grant=%b busy=%b exp=0/0000/0000/0",
                               instrValid, playerInstruction, grant, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        instrReady = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (instrValid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || got_q.size() != 0) begin
            n_fail++; $display("FAIL arst_idle activity=%b handshakes=%0d exp=0/0", !quiet, got_q.size());
        end
        instrReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_saturation();
        test_back_to_back();
        test_move();
        test_flush();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover exp=%0d got=%0d", exp_q.size(), got_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
